// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: sequential shift-and-add unsigned multiplier with a ripple-carry adder cell chain.
// Define APPROX_TRUNC_EN to zero the low TRUNC_BITS multiplicand bits at capture (approximate mode).
module adder (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = in1 ^ in2 ^ cin;
  assign carry = (in1 & in2) | (cin & (in1 ^ in2));
endmodule

module seq_shift_add_mult #(
  parameter int WIDTH      = 8,
  parameter int TRUNC_BITS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [WIDTH-1:0] mcand, mplier, acc, addend, sum, acc_n, mplier_n, a_cap;
  logic [WIDTH:0]   c;
  logic [CW-1:0]    cnt;
  logic             last;
`ifdef APPROX_TRUNC_EN
  assign a_cap = a & {{(WIDTH-TRUNC_BITS){1'b1}}, {TRUNC_BITS{1'b0}}};
`else
  assign a_cap = a;
`endif
  assign addend = mplier[0] ? mcand : '0;
  assign c[0]   = 1'b0;
  for (genvar g = 0; g < WIDTH; g++) begin : g_fa
    adder u_fa (.in1(acc[g]), .in2(addend[g]), .cin(c[g]), .sum(sum[g]), .carry(c[g+1]));
  end
  // The chain carry becomes the new accumulator MSB; the sum LSB shifts into the multiplier register.
  assign acc_n    = {c[WIDTH], sum[WIDTH-1:1]};
  assign mplier_n = {sum[0], mplier[WIDTH-1:1]};
  assign last     = cnt == CW'(WIDTH - 1);
  assign busy     = state == RUN;
  assign done     = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = IDLE;
    next = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (state == IDLE && start) begin
      mcand  <= a_cap;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_n;
      mplier <= mplier_n;
      cnt    <= cnt + CW'(1);
      if (last) product <= {acc_n, mplier_n};
    end
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb_seq_shift_add_mult: directed self-checking bench for seq_shift_add_mult (WIDTH=8).
module tb_seq_shift_add_mult;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [7:0]  a = 0;
  logic [7:0]  b = 0;
  logic        busy, done;
  logic [15:0] product;
  int passed = 0;
  int total = 0;

  seq_shift_add_mult #(.WIDTH(8), .TRUNC_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic mult(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input string tag);
    int n = 0;
    int bn = 0;
    @(negedge clk);
    a = x; b = y; start = 1;
    @(posedge clk); #1;
    check({tag, "_busy_accept"}, busy, 1);
    bn = busy ? 1 : 0;
    @(negedge clk);
    start = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (busy) bn++;
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_busy_cycles"}, bn, 8);
    check({tag, "_product"}, product, exp);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_product_hold"}, product, exp);
  endtask

  initial begin
    int dn;
    logic [15:0] cap;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    @(negedge clk);
    rst_n = 1;

    mult(8'hFF, 8'hFF, 16'hFE01, "max");
    repeat (3) @(posedge clk);
    #1 check("hold_idle", product, 16'hFE01);
    mult(8'h00, 8'hA5, 16'h0000, "zero_a");
    mult(8'h80, 8'h02, 16'h0100, "msb");

    // start re-asserted with new operands while running must be ignored
    @(negedge clk);
    a = 3; b = 5; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    a = 7; b = 7; start = 1;
    repeat (3) @(negedge clk);
    start = 0;
    dn = 0; cap = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) begin dn++; cap = product; end
    end
    check("busy_start_dones", dn, 1);
    check("busy_start_product", cap, 16'h000F);

    // reset in the middle of a run: asynchronous clear, no done afterwards
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check("midrun_busy_before", busy, 1);
    rst_n = 0;
    #1;
    check("midrun_busy", busy, 0);
    check("midrun_done", done, 0);
    check("midrun_product", product, 0);
    @(negedge clk);
    rst_n = 1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("midrun_no_done", dn, 0);
    mult(8'h02, 8'h03, 16'h0006, "after_reset");

`ifdef APPROX_TRUNC_EN
    mult(8'h0F, 8'h0F, 16'h00B4, "approx");
`else
    mult(8'h0F, 8'h0F, 16'h00E1, "exact");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seq_shift_add_mult.md
SEQ_SHIFT_ADD_MULT -- requirements
Module: seq_shift_add_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 The block SHALL have parameter TRUNC_BITS, default 2, giving the number of truncated multiplicand LSBs in approximate mode.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-004 Port clk SHALL be an input, 1 bit wide: the clock, rising-edge active.
REQ-005 Port rst_n SHALL be an input, 1 bit wide: the asynchronous, active-low reset.
REQ-006 Port start SHALL be an input, 1 bit wide: the request to begin a multiply.
REQ-007 Port a SHALL be an input, WIDTH bits wide: the unsigned multiplicand.
REQ-008 Port b SHALL be an input, WIDTH bits wide: the unsigned multiplier.
REQ-009 Port busy SHALL be an output, 1 bit wide: high while a multiply is running.
REQ-010 Port done SHALL be an output, 1 bit wide: a one-cycle pulse marking a valid product.
REQ-011 Port product SHALL be an output, 2*WIDTH bits wide: the unsigned result.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 at a rising edge, the block SHALL capture a and b, clear the accumulator and the iteration counter, and go to RUN.
REQ-014 In IDLE with start=0, the FSM SHALL stay in IDLE.
REQ-015 Each RUN cycle SHALL add the multiplicand into the upper WIDTH bits of the accumulator if the current multiplier LSB is 1, then shift the {carry, accumulator, multiplier} word right by one.
REQ-016 The RUN adder SHALL be a WIDTH-bit ripple chain of the team's 1-bit full-adder cell adder (in1, in2, cin, sum, carry), with cin of bit 0 tied to 0.
REQ-017 The carry out of the chain SHALL enter the accumulator MSB on the shift, so no product bit is lost.
REQ-018 RUN SHALL last exactly WIDTH cycles, counted by a clog2(WIDTH+1)-bit counter, and SHALL then go to DONE.
REQ-019 On entry to DONE, product SHALL be loaded and done SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-020 Latency SHALL be WIDTH+1 edges from the start-accepting edge to done=1.
REQ-021 busy SHALL be 1 only in RUN.
REQ-022 product SHALL hold its value until the next DONE.
REQ-023 start SHALL be ignored in RUN and in DONE; the operands of the running multiply SHALL be unaffected.
REQ-024 A start that is high in DONE SHALL NOT be accepted; a start that is held high into IDLE SHALL be accepted on the following edge.
REQ-025 If either operand is 0, product SHALL be 0 with the normal latency; there SHALL be no early termination.

Reset
REQ-026 When rst_n=0, asynchronously: the state SHALL be IDLE and busy, done, product, the accumulator, the counter and the operand registers SHALL all be 0.
REQ-027 A reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-028 A start after reset release SHALL operate normally.

Configuration
REQ-029 The macro APPROX_TRUNC_EN SHALL compile the approximate mode in or out.
REQ-030 With APPROX_TRUNC_EN defined, the captured multiplicand bits [TRUNC_BITS-1:0] SHALL be forced to 0, so product = (a with low TRUNC_BITS cleared) * b, with identical latency.
REQ-031 Without APPROX_TRUNC_EN, product SHALL be the exact a*b, and no masking logic SHALL be present.

Verification
REQ-032 Reset scenario: assert rst_n=0 at any time -> busy=0, done=0, product=0x0000 immediately.
REQ-033 Exact-max scenario: a=0xFF, b=0xFF, start for 1 cycle -> busy for 8 cycles, done at edge 9, product=0xFE01.
REQ-034 Edge-case scenario: a=0x00, b=0xA5 -> product=0x0000; a=0x80, b=0x02 -> product=0x0100; each with done at edge 9.
REQ-035 Busy-start scenario: start with a=3, b=5, then start with a=7, b=7 during RUN -> a single done, product=0x000F.
REQ-036 Mid-run reset scenario: a=0xFF, b=0xFF, rst_n low on RUN cycle 4 -> no done, outputs 0; next start with a=2, b=3 -> product=0x0006.
REQ-037 Approximate scenario: APPROX_TRUNC_EN defined, TRUNC_BITS=2, a=0x0F, b=0x0F -> product=0x00B4; the same stimulus without the macro -> product=0x00E1.
